sdram_burst_streamer: RTL and testbench



---
 rtl/sdram_pkg.sv | 35 +++
 rtl/sdram_burst_streamer_if.sv | 28 ++
 rtl/sdram_burst_fifo.sv | 73 +++++++
 rtl/sdram_burst_streamer.sv | 164 ++++++++++++++++
 tb/tb_sdram_burst_streamer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg
// Shared constants and types for clients of the SDRAM controller's CPU port.
//   BURST_WORDS   : 16-bit words delivered per controller burst
//   BURST_BYTES   : byte stride between consecutive bursts
//   SD_ADDR_W     : width of the controller byte address
//   fetch_state_t : states of the burst fetch FSM
//   burst_word()  : picks one 16-bit word out of a 64-bit burst, word 0 first
package sdram_pkg;

    localparam int BURST_WORDS = 4;
    localparam int BURST_BYTES = 8;
    localparam int SD_ADDR_W   = 25;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACK,
        WAIT,
        PUSH
    } fetch_state_t;

    // Word 0 sits in the most significant lane, matching the controller.
    function automatic logic [15:0] burst_word(input logic [63:0] burst,
                                               input logic [1:0]  word_idx);
        logic [15:0] w;
        case (word_idx)
            2'd0:    w = burst[63:48];
            2'd1:    w = burst[47:32];
            2'd2:    w = burst[31:16];
            default: w = burst[15:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sdram_burst_streamer_if.sv
// sdram_burst_streamer_if
// Bundles the controller read pins and the outgoing word stream.
//   sd_addr, sd_rd           : request to the controller
//   sd_ready_fourth, sd_dout : burst completion and data from the controller
//   q_data, q_valid, q_ready : 16-bit valid/ready word stream to the consumer
// master: the streamer side. slave: the controller plus consumer side.
interface sdram_burst_streamer_if;
    import sdram_pkg::*;

    logic [SD_ADDR_W-1:0] sd_addr;
    logic                 sd_rd;
    logic                 sd_ready_fourth;
    logic [63:0]          sd_dout;
    logic [15:0]          q_data;
    logic                 q_valid;
    logic                 q_ready;

    modport master (
        output sd_addr, sd_rd, q_data, q_valid,
        input  sd_ready_fourth, sd_dout, q_ready
    );

    modport slave (
        input  sd_addr, sd_rd, q_data, q_valid,
        output sd_ready_fourth, sd_dout, q_ready
    );

endinterface

// File: rtl/sdram_burst_fifo.sv
// sdram_burst_fifo
// Synchronous FIFO with registered full/empty flags and an occupancy count.
//   clk, rst        : clock, asynchronous active-high reset
//   wr_en, wr_data  : push (ignored when full unless a pop happens together)
//   rd_en, rd_data  : pop (ignored when empty); rd_data shows the head entry
//   full, empty     : registered status flags
//   count           : number of stored entries
module sdram_burst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;
    logic [CW-1:0]    count_next;

    // A full FIFO can still accept a write when the head is leaving this cycle.
    always_comb begin
        do_rd      = rd_en && !empty;
        do_wr      = wr_en && (!full || do_rd);
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_next = count - CW'(1);
        end
    end

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/sdram_burst_streamer.sv
// sdram_burst_streamer
// Walks a linear SDRAM region in 64-bit bursts with one read in flight,
// buffers returned bursts and serialises them into a 16-bit word stream.
//   clk, init            : clock, asynchronous active-high reset
//   start                : one-cycle stream request (ignored while busy)
//   base_addr            : byte address of the stream, forced to 8-byte alignment
//   burst_count          : bursts to read; 0 gives an immediate done
//   busy, done           : stream in progress / one-cycle completion pulse
//   bus (master modport) : controller read pins and the output word stream
module sdram_burst_streamer
    import sdram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic                  start,
    input  logic [SD_ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]      burst_count,
    output logic                  busy,
    output logic                  done,
    sdram_burst_streamer_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SD_ADDR_W-1:0] ALIGN_MASK = ~SD_ADDR_W'(BURST_BYTES - 1);
    localparam logic [SD_ADDR_W-1:0] ADDR_STEP  = SD_ADDR_W'(BURST_BYTES);
    localparam logic [1:0]           LAST_IDX   = 2'(BURST_WORDS - 1);
    localparam logic [CNT_W-1:0]     SLOT_LIMIT = CNT_W'(FIFO_DEPTH - 1);

    fetch_state_t          state;
    logic [SD_ADDR_W-1:0]  cur_addr;
    logic [SD_ADDR_W-1:0]  next_addr;
    logic [SD_ADDR_W-1:0]  start_addr;
    logic [SD_ADDR_W-1:0]  sd_addr_q;
    logic                  sd_rd_q;
    logic [LEN_W-1:0]      remaining;
    logic [1:0]            idx;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [63:0]           fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  handshake;
    logic                  slot_after_push;
    logic                  can_issue;

    // slot_after_push looks through the push landing this cycle (and any pop
    // leaving) so the next request can go out straight from PUSH while still
    // guaranteeing its burst a free slot.
    always_comb begin
        start_addr      = base_addr & ALIGN_MASK;
        next_addr       = cur_addr + ADDR_STEP;
        fifo_push       = (state == PUSH);
        handshake       = !fifo_empty && bus.q_ready;
        fifo_pop        = handshake && (idx == LAST_IDX);
        slot_after_push = (fifo_count < SLOT_LIMIT) || fifo_pop;
        can_issue       = !fifo_full && bus.sd_ready_fourth;
    end

    assign bus.sd_addr = sd_addr_q;
    assign bus.sd_rd   = sd_rd_q;
    assign bus.q_valid = !fifo_empty;
    assign bus.q_data  = fifo_empty ? '0 : burst_word(fifo_head, idx);

    sdram_burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (init),
        .wr_en   (fifo_push),
        .wr_data (bus.sd_dout),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ISSUE doubles as the stall point: sd_rd stays low there until a slot is
    // free and the controller is ready, then is held high for one cycle.
    // In ACK a still-high sd_ready_fourth means the controller served a
    // same-address hit, so the current sd_dout is taken without re-issuing.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            sd_addr_q <= '0;
            sd_rd_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        cur_addr  <= start_addr;
                        remaining <= burst_count;
                        if (burst_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= ISSUE;
                            if (can_issue) begin
                                sd_rd_q   <= 1'b1;
                                sd_addr_q <= start_addr;
                            end
                        end
                    end else if (busy && remaining == '0 && fifo_empty && idx == '0) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (sd_rd_q) begin
                        sd_rd_q <= 1'b0;
                        state   <= ACK;
                    end else if (can_issue) begin
                        sd_rd_q   <= 1'b1;
                        sd_addr_q <= cur_addr;
                    end
                end
                ACK: begin
                    state <= bus.sd_ready_fourth ? PUSH : WAIT;
                end
                WAIT: begin
                    if (bus.sd_ready_fourth) begin
                        state <= PUSH;
                    end
                end
                PUSH: begin
                    cur_addr  <= next_addr;
                    remaining <= remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        state <= ISSUE;
                        if (slot_after_push && bus.sd_ready_fourth) begin
                            sd_rd_q   <= 1'b1;
                            sd_addr_q <= next_addr;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Word index into the head burst; the pop on the last word rewinds it.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            idx <= '0;
        end else if (handshake) begin
            idx <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_sdram_burst_streamer.sv
// tb_sdram_burst_streamer
// Directed bench for sdram_burst_streamer with a small controller model that
// answers each sd_rd rising edge after a programmable latency, or as a cache
// hit that keeps sd_ready_fourth high.
module tb_sdram_burst_streamer;

    logic        clk = 1'b0;
    logic        init;
    logic        start;
    logic [24:0] base_addr;
    logic [15:0] burst_count;
    logic        busy;
    logic        done;

    int vectors    = 0;
    int miscompares = 0;

    sdram_burst_streamer_if bus_if ();

    sdram_burst_streamer #(
        .FIFO_DEPTH (4),
        .LEN_W      (16)
    ) dut (
        .clk         (clk),
        .init        (init),
        .start       (start),
        .base_addr   (base_addr),
        .burst_count (burst_count),
        .busy        (busy),
        .done        (done),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    // Controller model and monitors, all sampled on the falling edge.
    logic [63:0] mdata    [64];
    logic [24:0] addr_log [64];
    logic [15:0] word_log [256];
    int  rd_pulses  = 0;
    int  word_cnt   = 0;
    int  done_cnt   = 0;
    int  pend_idx   = 0;
    int  lat_left   = 0;
    int  lat_cycles = 3;
    bit  hit_mode   = 1'b0;
    bit  prev_rd    = 1'b0;
    bit  model_init = 1'b0;

    always @(negedge clk) begin
        if (!model_init) begin
            bus_if.sd_ready_fourth = 1'b1;
            bus_if.sd_dout         = '0;
            model_init             = 1'b1;
        end
        if (bus_if.sd_rd && !prev_rd) begin
            if (rd_pulses < 64) addr_log[rd_pulses] = bus_if.sd_addr;
            pend_idx = rd_pulses;
            if (hit_mode) begin
                bus_if.sd_dout = mdata[pend_idx % 64];
            end else begin
                bus_if.sd_ready_fourth = 1'b0;
                lat_left = lat_cycles;
            end
            rd_pulses++;
        end else if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) begin
                bus_if.sd_dout         = mdata[pend_idx % 64];
                bus_if.sd_ready_fourth = 1'b1;
            end
        end
        prev_rd = bus_if.sd_rd;
        if (done) done_cnt++;
        if (bus_if.q_valid && bus_if.q_ready) begin
            if (word_cnt < 256) word_log[word_cnt] = bus_if.q_data;
            word_cnt++;
        end
    end

    function automatic logic [15:0] exp_word(input logic [7:0] tag, input int k, input int w);
        return {tag, 6'(k), 2'(w)};
    endfunction

    task automatic fill_data(input int first, input int n, input logic [7:0] tag);
        for (int k = 0; k < n; k++) begin
            mdata[(first + k) % 64] = {exp_word(tag, k, 0), exp_word(tag, k, 1),
                                       exp_word(tag, k, 2), exp_word(tag, k, 3)};
        end
    endtask

    task automatic pulse_start(input logic [24:0] addr, input logic [15:0] cnt);
        @(posedge clk); #2;
        base_addr   = addr;
        burst_count = cnt;
        start       = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_done, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #3;
            if (done_cnt > base_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        vectors++; if (bus_if.sd_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sd_rd: got %b expected 0", bus_if.sd_rd); end
        vectors++; if (bus_if.sd_addr !== 25'h0) begin miscompares++; $display("[TB] FAIL reset_sd_addr: got %h expected 0", bus_if.sd_addr); end
        vectors++; if (bus_if.q_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_q_valid: got %b expected 0", bus_if.q_valid); end
        vectors++; if (bus_if.q_data !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_q_data: got %h expected 0", bus_if.q_data); end
        init = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        vectors++; if (busy !== 1'b0 || bus_if.sd_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_after_reset: got busy=%b sd_rd=%b expected 0/0", busy, bus_if.sd_rd); end
    endtask

    task automatic test_basic_stream();
        logic [15:0] exp [8];
        int r0, w0, d0;
        bit ok;
        exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        r0 = rd_pulses; w0 = word_cnt; d0 = done_cnt;
        mdata[r0 % 64]       = 64'h1111_2222_3333_4444;
        mdata[(r0 + 1) % 64] = 64'h5555_6666_7777_8888;
        pulse_start(25'h000100, 16'd2);
        vectors++; if (bus_if.sd_rd !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_rd_latency: got %b expected 1", bus_if.sd_rd); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
        wait_done(d0, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL basic_done_timeout: got no done expected done within 200 cycles"); end
        repeat (3) @(posedge clk);
        #2;
        vectors++; if (rd_pulses - r0 !== 2) begin miscompares++; $display("[TB] FAIL basic_rd_count: got %0d expected 2", rd_pulses - r0); end
        vectors++; if (addr_log[r0 % 64] !== 25'h100) begin miscompares++; $display("[TB] FAIL basic_addr0: got %h expected 100", addr_log[r0 % 64]); end
        vectors++; if (addr_log[(r0 + 1) % 64] !== 25'h108) begin miscompares++; $display("[TB] FAIL basic_addr1: got %h expected 108", addr_log[(r0 + 1) % 64]); end
        vectors++; if (word_cnt - w0 !== 8) begin miscompares++; $display("[TB] FAIL basic_word_count: got %0d expected 8", word_cnt - w0); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (word_log[(w0 + i) % 256] !== exp[i]) begin miscompares++; $display("[TB] FAIL basic_word%0d: got %h expected %h", i, word_log[(w0 + i) % 256], exp[i]); end
        end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int r0, w0, d0;
        bit ok;
        r0 = rd_pulses; w0 = word_cnt; d0 = done_cnt;
        fill_data(r0, 10, 8'hB3);
        bus_if.q_ready = 1'b0;
        pulse_start(25'h002000, 16'd10);
        repeat (60) @(posedge clk);
        #2;
        vectors++; if (rd_pulses - r0 !== 4) begin miscompares++; $display("[TB] FAIL bp_rd_stall: got %0d expected 4", rd_pulses - r0); end
        vectors++; if (bus_if.q_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_q_valid: got %b expected 1", bus_if.q_valid); end
        vectors++; if (bus_if.q_data !== exp_word(8'hB3, 0, 0)) begin miscompares++; $display("[TB] FAIL bp_head_word: got %h expected %h", bus_if.q_data, exp_word(8'hB3, 0, 0)); end
        bus_if.q_ready = 1'b1;
        wait_done(d0, 1000, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL bp_done_timeout: got no done expected done within 1000 cycles"); end
        repeat (3) @(posedge clk);
        #2;
        vectors++; if (rd_pulses - r0 !== 10) begin miscompares++; $display("[TB] FAIL bp_rd_total: got %0d expected 10", rd_pulses - r0); end
        vectors++; if (addr_log[(r0 + 9) % 64] !== 25'h002048) begin miscompares++; $display("[TB] FAIL bp_last_addr: got %h expected 2048", addr_log[(r0 + 9) % 64]); end
        vectors++; if (word_cnt - w0 !== 40) begin miscompares++; $display("[TB] FAIL bp_word_count: got %0d expected 40", word_cnt - w0); end
        for (int k = 0; k < 10; k++) begin
            for (int w = 0; w < 4; w++) begin
                vectors++; if (word_log[(w0 + 4 * k + w) % 256] !== exp_word(8'hB3, k, w)) begin miscompares++; $display("[TB] FAIL bp_word_b%0d_w%0d: got %h expected %h", k, w, word_log[(w0 + 4 * k + w) % 256], exp_word(8'hB3, k, w)); end
            end
        end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL bp_done_pulses: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_cache_hit();
        int r0, w0, d0;
        bit ok;
        r0 = rd_pulses; w0 = word_cnt; d0 = done_cnt;
        fill_data(r0, 1, 8'hC7);
        hit_mode = 1'b1;
        pulse_start(25'h000300, 16'd1);
        repeat (3) @(posedge clk);
        #2;
        vectors++; if (bus_if.q_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hit_q_valid_timing: got %b expected 1", bus_if.q_valid); end
        vectors++; if (bus_if.q_data !== exp_word(8'hC7, 0, 0)) begin miscompares++; $display("[TB] FAIL hit_first_word: got %h expected %h", bus_if.q_data, exp_word(8'hC7, 0, 0)); end
        wait_done(d0, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL hit_done_timeout: got no done expected done within 100 cycles"); end
        repeat (3) @(posedge clk);
        #2;
        hit_mode = 1'b0;
        vectors++; if (rd_pulses - r0 !== 1) begin miscompares++; $display("[TB] FAIL hit_rd_count: got %0d expected 1", rd_pulses - r0); end
        vectors++; if (word_cnt - w0 !== 4) begin miscompares++; $display("[TB] FAIL hit_word_count: got %0d expected 4", word_cnt - w0); end
        for (int w = 0; w < 4; w++) begin
            vectors++; if (word_log[(w0 + w) % 256] !== exp_word(8'hC7, 0, w)) begin miscompares++; $display("[TB] FAIL hit_word%0d: got %h expected %h", w, word_log[(w0 + w) % 256], exp_word(8'hC7, 0, w)); end
        end
    endtask

    task automatic test_zero_count();
        int r0, d0;
        r0 = rd_pulses; d0 = done_cnt;
        pulse_start(25'h000500, 16'd0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_done_timing: got %b expected 1", done); end
        @(posedge clk); #2;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done_width: got %b expected 0", done); end
        repeat (5) @(posedge clk);
        #2;
        vectors++; if (rd_pulses - r0 !== 0) begin miscompares++; $display("[TB] FAIL zero_no_rd: got %0d expected 0", rd_pulses - r0); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL zero_done_pulses: got %0d expected 1", done_cnt - d0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy: got %b expected 0", busy); end
    endtask

    task automatic test_addr_wrap();
        int r0, w0, d0;
        bit ok;
        r0 = rd_pulses; w0 = word_cnt; d0 = done_cnt;
        fill_data(r0, 2, 8'h5A);
        pulse_start(25'h1FFFFFF, 16'd2);
        wait_done(d0, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL wrap_done_timeout: got no done expected done within 200 cycles"); end
        vectors++; if (addr_log[r0 % 64] !== 25'h1FFFFF8) begin miscompares++; $display("[TB] FAIL wrap_addr0: got %h expected 1fffff8", addr_log[r0 % 64]); end
        vectors++; if (addr_log[(r0 + 1) % 64] !== 25'h0000000) begin miscompares++; $display("[TB] FAIL wrap_addr1: got %h expected 0", addr_log[(r0 + 1) % 64]); end
        vectors++; if (word_log[(w0 + 7) % 256] !== exp_word(8'h5A, 1, 3)) begin miscompares++; $display("[TB] FAIL wrap_last_word: got %h expected %h", word_log[(w0 + 7) % 256], exp_word(8'h5A, 1, 3)); end
    endtask

    task automatic test_init_midstream();
        int r1, w1, d1;
        bit ok;
        fill_data(rd_pulses, 3, 8'hE1);
        lat_cycles = 10;
        pulse_start(25'h000400, 16'd3);
        repeat (4) @(posedge clk);
        #2;
        init = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL init_busy: got %b expected 0", busy); end
        vectors++; if (bus_if.sd_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL init_sd_rd: got %b expected 0", bus_if.sd_rd); end
        vectors++; if (bus_if.sd_addr !== 25'h0) begin miscompares++; $display("[TB] FAIL init_sd_addr: got %h expected 0", bus_if.sd_addr); end
        vectors++; if (bus_if.q_valid !== 1'b0 || bus_if.q_data !== 16'h0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL init_stream: got valid=%b data=%h done=%b expected 0/0000/0", bus_if.q_valid, bus_if.q_data, done); end
        @(posedge clk); #2;
        init = 1'b0;
        repeat (15) @(posedge clk);
        lat_cycles = 3;
        r1 = rd_pulses; w1 = word_cnt; d1 = done_cnt;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL init_stale_burst: got busy=%b expected 0", busy); end
        fill_data(r1, 1, 8'h2D);
        pulse_start(25'h000508, 16'd1);
        wait_done(d1, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL restart_done_timeout: got no done expected done within 200 cycles"); end
        vectors++; if (addr_log[r1 % 64] !== 25'h000508) begin miscompares++; $display("[TB] FAIL restart_addr: got %h expected 508", addr_log[r1 % 64]); end
        vectors++; if (word_cnt - w1 !== 4) begin miscompares++; $display("[TB] FAIL restart_word_count: got %0d expected 4", word_cnt - w1); end
        for (int w = 0; w < 4; w++) begin
            vectors++; if (word_log[(w1 + w) % 256] !== exp_word(8'h2D, 0, w)) begin miscompares++; $display("[TB] FAIL restart_word%0d: got %h expected %h", w, word_log[(w1 + w) % 256], exp_word(8'h2D, 0, w)); end
        end
    endtask

    initial begin
        init           = 1'b1;
        start          = 1'b0;
        base_addr      = '0;
        burst_count    = '0;
        bus_if.q_ready = 1'b1;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_cache_hit();
        test_zero_count();
        test_addr_wrap();
        test_init_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
